vga_sync_gen: RTL and testbench

Timing source for the Pong display pipeline. Divides the 100 MHz board clock into a pixel-rate enable and runs horizontal and vertical counters for 640x480 at 60 Hz. Drives the VGA connector's hsync and vsync pins. Supplies `x`, `y`, `video_on` and a once-per-frame tick to the graphics generator, which returns 12-bit `rgb` for the current pixel.

---
 rtl/vga_sync_gen.sv | 89 ++++++++
 tb/tb_vga_sync_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel-rate enable, x/y counters, registered active-low syncs
// aligned with the counters, visible-area flag and a start-of-vblank tick.
`timescale 1ns/1ps
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    assign p_tick   = (div_cnt == DIV_LAST);
    assign video_on = (x < H_VIS) && (y < V_VIS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Counters wrap by explicit compare so no out-of-range value is reachable.
    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Syncs and frame tick are registered from the next-state counters so
    // they line up with the x/y presented on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            x          <= x_next;
            y          <= y_next;
            hsync      <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync      <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            frame_tick <= p_tick && (x == H_LAST) && (y_next == V_VIS);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a shrunken raster; outputs are compared every
// cycle against a model derived from the number of clocks since reset release.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    localparam int CLK_DIV = 4;
    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;
    localparam logic [24:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};

    logic       clk;
    logic       reset;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_sync_gen #(
        .CLK_DIV(CLK_DIV),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p_tick(p_tick),
        .x(x),
        .y(y),
        .video_on(video_on),
        .hsync(hsync),
        .vsync(vsync),
        .frame_tick(frame_tick)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: everything follows from the clock count since reset release.
    function automatic logic [24:0] model(input int t);
        int  n, pos, mx, my;
        bit  pt, vo, hs, vs, ft;
        pt  = (t % CLK_DIV) == (CLK_DIV - 1);
        n   = t / CLK_DIV;
        pos = n % (HT * VT);
        mx  = pos % HT;
        my  = pos / HT;
        vo  = (mx < HD) && (my < VD);
        hs  = !((mx >= HD + HF) && (mx < HD + HF + HS));
        vs  = !((my >= VD + VF) && (my < VD + VF + VS));
        ft  = (t > 0) && ((t % CLK_DIV) == 0) && (mx == 0) && (my == VD);
        return {pt, 10'(mx), 10'(my), vo, hs, vs, ft};
    endfunction

    function automatic logic [24:0] observed();
        return {p_tick, x, y, video_on, hsync, vsync, frame_tick};
    endfunction

    int t_since_rst = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) t_since_rst <= 0;
        else        t_since_rst <= t_since_rst + 1;
    end

    int  cyc = 0;
    int  last_ft = 0;
    bit  last_ft_valid = 0;
    int  spacing_checks = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle scoreboard plus frame_tick spacing within an unbroken run.
    always @(negedge clk) begin
        check("cycle_outputs", 32'(observed()), 32'(model(t_since_rst)));
        if (!reset) begin
            last_ft_valid = 0;
        end else if (frame_tick) begin
            if (last_ft_valid) begin
                check("frame_tick_spacing", cyc - last_ft, FRAME_CLKS);
                spacing_checks++;
            end
            last_ft       = cyc;
            last_ft_valid = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_reset(input int hold);
        @(negedge clk);
        #($urandom_range(1, 4));
        reset = 1'b0;
        #1;
        check("async_clear", 32'(observed()), 32'(RST_VEC));
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic run_clocks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 32'(observed()), 32'(RST_VEC));
        #2 reset = 1'b1;

        run_clocks(FRAME_CLKS * 2 + FRAME_CLKS / 2);

        for (int i = 0; i < 4; i++) begin
            pulse_reset($urandom_range(1, 5));
            run_clocks($urandom_range(50, FRAME_CLKS + 200));
        end

        pulse_reset(3);
        run_clocks(FRAME_CLKS * 2 + 20);

        check("frame_spacing_seen", 32'(spacing_checks > 0), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
